// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM state codes,
// time-field widths and limits, and a wrapping +/-1 helper for the set modes.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PAUSE   = 3'd2,
      ST_SET_MIN = 3'd3,
      ST_SET_SEC = 3'd4
   } state_t;

   localparam int MIN_W = 6;
   localparam int SEC_W = 6;
   localparam int CS_W  = 7;

   localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;
   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

   // Out-of-range values snap to the nearest legal end rather than walking through garbage.
   function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                            input logic [5:0] max_v,
                                            input logic       up);
      if (up) begin
         return (v >= max_v) ? 6'd0 : v + 6'd1;
      end
      return (v == 6'd0 || v > max_v) ? max_v : v - 6'd1;
   endfunction

endpackage

// File: rtl/stopwatch_sequencer_if.sv
// User-input and display-output bundle of the stopwatch sequencer.
// master = stimulus side (encoder/buttons), slave = the sequencer.
interface stopwatch_sequencer_if #(
   parameter int ENC_W = 8
);
   logic [ENC_W-1:0] enc_value;
   logic             btn_start;
   logic             btn_mode;
   logic             btn_lap;
   logic [2:0]       state;
   logic             running;
   logic             overflow;
   logic [5:0]       disp_min;
   logic [5:0]       disp_sec;
   logic [6:0]       disp_cs;
   logic             lap_active;

   modport master (
      output enc_value, btn_start, btn_mode, btn_lap,
      input  state, running, overflow, disp_min, disp_sec, disp_cs, lap_active
   );

   modport slave (
      input  enc_value, btn_start, btn_mode, btn_lap,
      output state, running, overflow, disp_min, disp_sec, disp_cs, lap_active
   );
endinterface

// File: rtl/stopwatch_tick_gen.sv
// Centisecond prescaler: counts only while en is high, sits at zero otherwise,
// and pulses tick on the last count of each CLK_DIV-cycle period.
module stopwatch_tick_gen #(
   parameter int CLK_DIV = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = en && !rst && (cnt_q == LAST);
      cnt_d = '0;
      if (en && !tick) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch control FSM: start/pause/clear, time base, encoder-driven setting.
// Define STOPWATCH_LAP_EN to enable the lap (frozen display) feature.
module stopwatch_sequencer
   import stopwatch_pkg::*;
#(
   parameter int CLK_DIV = 1000000,
   parameter int ENC_W   = 8,
   parameter int MAX_MIN = 59
) (
   input logic                  clk,
   input logic                  rst,
   stopwatch_sequencer_if.slave bus
);
   localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

   state_t            state_q, state_d;
   logic [MIN_W-1:0]  min_q, min_d;
   logic [SEC_W-1:0]  sec_q, sec_d;
   logic [CS_W-1:0]   cs_q, cs_d;
   logic              ovf_q, ovf_d;
   logic              running_q;
   logic [ENC_W-1:0]  enc_prev_q;
   logic [ENC_W-1:0]  delta;
   logic              step_up, step_dn;
   logic              tick;
   logic              at_max;

   stopwatch_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == ST_RUN),
      .tick (tick)
   );

   assign delta   = bus.enc_value - enc_prev_q;
   assign step_up = (delta == ENC_W'(1));
   assign step_dn = (delta == '1);
   assign at_max  = (min_q == MAX_MIN_V) && (sec_q == SEC_MAX) && (cs_q == CS_MAX);

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      cs_d    = cs_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.btn_start)     state_d = ST_RUN;
            else if (bus.btn_mode) state_d = ST_SET_MIN;
         end
         ST_RUN: begin
            if (tick) begin
               if (at_max) begin
                  ovf_d   = 1'b1;
                  state_d = ST_PAUSE;
               end else if (cs_q == CS_MAX) begin
                  cs_d = '0;
                  if (sec_q == SEC_MAX) begin
                     sec_d = '0;
                     min_d = min_q + 1'b1;
                  end else begin
                     sec_d = sec_q + 1'b1;
                  end
               end else begin
                  cs_d = cs_q + 1'b1;
               end
            end
            if (bus.btn_start) state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (bus.btn_start) begin
               state_d = ST_RUN;
            end else if (bus.btn_mode) begin
               state_d = ST_IDLE;
               min_d   = '0;
               sec_d   = '0;
               cs_d    = '0;
               ovf_d   = 1'b0;
            end
         end
         ST_SET_MIN: begin
            if (step_up || step_dn) min_d = wrap_step(min_q, MAX_MIN_V, step_up);
            if (bus.btn_start)     state_d = ST_RUN;
            else if (bus.btn_mode) state_d = ST_SET_SEC;
         end
         ST_SET_SEC: begin
            if (step_up || step_dn) sec_d = wrap_step(sec_q, SEC_MAX, step_up);
            if (bus.btn_start)     state_d = ST_RUN;
            else if (bus.btn_mode) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Setting always starts from whole seconds.
      if (state_d == ST_SET_MIN && state_q != ST_SET_MIN) cs_d = '0;
   end

   always_ff @(posedge clk) begin
      enc_prev_q <= bus.enc_value;
      if (rst) begin
         state_q   <= ST_IDLE;
         min_q     <= '0;
         sec_q     <= '0;
         cs_q      <= '0;
         ovf_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         cs_q      <= cs_d;
         ovf_q     <= ovf_d;
         running_q <= (state_d == ST_RUN);
      end
   end

   assign bus.state    = state_q;
   assign bus.running  = running_q;
   assign bus.overflow = ovf_q;

`ifdef STOPWATCH_LAP_EN
   logic             lap_q, lap_d;
   logic [MIN_W-1:0] lap_min_q, lap_min_d;
   logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
   logic [CS_W-1:0]  lap_cs_q, lap_cs_d;

   always_comb begin
      lap_d     = lap_q;
      lap_min_d = lap_min_q;
      lap_sec_d = lap_sec_q;
      lap_cs_d  = lap_cs_q;
      if (state_q == ST_RUN && bus.btn_lap) begin
         lap_d = !lap_q;
         if (!lap_q) begin
            lap_min_d = min_q;
            lap_sec_d = sec_q;
            lap_cs_d  = cs_q;
         end
      end
      // The frozen value survives PAUSE but not a trip back to IDLE or a set mode.
      if (state_d == ST_IDLE || state_d == ST_SET_MIN || state_d == ST_SET_SEC) lap_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lap_q     <= 1'b0;
         lap_min_q <= '0;
         lap_sec_q <= '0;
         lap_cs_q  <= '0;
      end else begin
         lap_q     <= lap_d;
         lap_min_q <= lap_min_d;
         lap_sec_q <= lap_sec_d;
         lap_cs_q  <= lap_cs_d;
      end
   end

   assign bus.lap_active = lap_q;
   assign bus.disp_min   = lap_q ? lap_min_q : min_q;
   assign bus.disp_sec   = lap_q ? lap_sec_q : sec_q;
   assign bus.disp_cs    = lap_q ? lap_cs_q  : cs_q;
`else
   logic unused_btn_lap;
   assign unused_btn_lap = bus.btn_lap;
   assign bus.lap_active = 1'b0;
   assign bus.disp_min   = min_q;
   assign bus.disp_sec   = sec_q;
   assign bus.disp_cs    = cs_q;
`endif

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer (CLK_DIV=4): vector table for the
// start/pause/set/overflow flow plus hand-written reset and lap sequences.
module tb_stopwatch_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stopwatch_sequencer_if #(.ENC_W(8)) bus ();

   stopwatch_sequencer #(.CLK_DIV(4), .ENC_W(8), .MAX_MIN(59)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       start;
      logic       mode;
      logic [7:0] enc;
      int         cycles;
      logic [2:0] st;
      logic       ovf;
      int         mn;
      int         sc;
      int         cs;
   } vec_t;

   vec_t vt[64];
   int   nv = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic add(input logic s, input logic m, input logic [7:0] e, input int cyc,
                      input logic [2:0] st, input logic ov, input int mn, input int sc, input int cs);
      vt[nv] = '{start: s, mode: m, enc: e, cycles: cyc, st: st, ovf: ov, mn: mn, sc: sc, cs: cs};
      nv++;
   endtask

   function automatic logic [24:0] pack_exp(input logic [2:0] st, input logic ov, input int mn,
                                            input int sc, input int cs, input logic lap);
      return {st, (st == 3'd1), ov, 6'(mn), 6'(sc), 7'(cs), lap};
   endfunction

   function automatic logic [24:0] actual();
      return {bus.state, bus.running, bus.overflow, bus.disp_min, bus.disp_sec,
              bus.disp_cs, bus.lap_active};
   endfunction

   task automatic check(input string nm, input logic [24:0] act, input logic [24:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got st=%0d run=%0d ovf=%0d %0d:%0d.%0d lap=%0d, expected st=%0d run=%0d ovf=%0d %0d:%0d.%0d lap=%0d",
                  nm, act[24:22], act[21], act[20], act[19:14], act[13:8], act[7:1], act[0],
                  exp[24:22], exp[21], exp[20], exp[19:14], exp[13:8], exp[7:1], exp[0]);
      end
   endtask

   task automatic clk_step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.btn_start = 1'b0;
         bus.btn_mode  = 1'b0;
         bus.btn_lap   = 1'b0;
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.enc_value = 8'd0;
      bus.btn_start = 1'b0;
      bus.btn_mode  = 1'b0;
      bus.btn_lap   = 1'b0;
      clk_step(2);
      rst = 1'b0;
      check("reset", actual(), pack_exp(3'd0, 1'b0, 0, 0, 0, 1'b0));

      //  start mode enc  cyc  state ovf  mm ss cs
      add(1, 0, 8'd0,   1,   3'd1, 0,  0, 0, 0);    // IDLE start -> RUN
      add(0, 0, 8'd0,   400, 3'd1, 0,  0, 1, 0);    // 100 ticks
      add(1, 0, 8'd0,   1,   3'd2, 0,  0, 1, 0);    // pause
      add(0, 0, 8'd0,   50,  3'd2, 0,  0, 1, 0);    // time holds
      add(0, 1, 8'd0,   1,   3'd0, 0,  0, 0, 0);    // clear
      add(0, 1, 8'd0,   1,   3'd3, 0,  0, 0, 0);    // SET_MIN
      add(0, 0, 8'd255, 1,   3'd3, 0,  59, 0, 0);   // -1 wraps
      add(0, 0, 8'd0,   1,   3'd3, 0,  0, 0, 0);    // +1
      add(0, 0, 8'd1,   1,   3'd3, 0,  1, 0, 0);    // +1
      add(0, 1, 8'd1,   1,   3'd4, 0,  1, 0, 0);    // SET_SEC
      add(0, 0, 8'd0,   1,   3'd4, 0,  1, 59, 0);   // -1 wraps
      add(0, 1, 8'd0,   1,   3'd0, 0,  1, 59, 0);   // back to IDLE keeping value
      add(1, 1, 8'd0,   1,   3'd1, 0,  1, 59, 0);   // start beats mode
      add(0, 0, 8'd1,   1,   3'd1, 0,  1, 59, 0);   // encoder ignored in RUN
      add(0, 0, 8'd0,   1,   3'd1, 0,  1, 59, 0);
      add(0, 0, 8'd0,   2,   3'd1, 0,  1, 59, 1);   // first tick 4 cycles after entry
      add(1, 0, 8'd0,   1,   3'd2, 0,  1, 59, 1);
      add(0, 1, 8'd0,   1,   3'd0, 0,  0, 0, 0);
      add(0, 1, 8'd0,   1,   3'd3, 0,  0, 0, 0);
      add(0, 0, 8'd255, 1,   3'd3, 0,  59, 0, 0);
      add(0, 1, 8'd255, 1,   3'd4, 0,  59, 0, 0);
      add(0, 0, 8'd254, 1,   3'd4, 0,  59, 59, 0);
      add(1, 0, 8'd254, 1,   3'd1, 0,  59, 59, 0);
      add(0, 0, 8'd254, 396, 3'd1, 0,  59, 59, 99); // 99 ticks
      add(0, 0, 8'd254, 4,   3'd2, 1,  59, 59, 99); // saturate
      add(0, 1, 8'd254, 1,   3'd0, 0,  0, 0, 0);    // clear overflow

      for (int v = 0; v < nv; v++) begin
         bus.btn_start = vt[v].start;
         bus.btn_mode  = vt[v].mode;
         bus.enc_value = vt[v].enc;
         clk_step(vt[v].cycles);
         $display("vec %0d: state=%0d ovf=%0d time=%0d:%0d.%0d", v, bus.state, bus.overflow,
                  bus.disp_min, bus.disp_sec, bus.disp_cs);
         check($sformatf("vec%0d", v), actual(),
               pack_exp(vt[v].st, vt[v].ovf, vt[v].mn, vt[v].sc, vt[v].cs, 1'b0));
      end

      // Reset mid-RUN one cycle before a tick is due.
      bus.btn_start = 1'b1;
      clk_step(1);
      clk_step(1311);
      check("run_3_27", actual(), pack_exp(3'd1, 1'b0, 0, 3, 27, 1'b0));
      rst = 1'b1;
      clk_step(1);
      check("rst_mid_run", actual(), pack_exp(3'd0, 1'b0, 0, 0, 0, 1'b0));
      rst = 1'b0;
      clk_step(5);
      check("after_rst", actual(), pack_exp(3'd0, 1'b0, 0, 0, 0, 1'b0));

`ifdef STOPWATCH_LAP_EN
      bus.btn_start = 1'b1;
      clk_step(1);
      clk_step(840);
      check("lap_pre", actual(), pack_exp(3'd1, 1'b0, 0, 2, 10, 1'b0));
      bus.btn_lap = 1'b1;
      clk_step(1);
      check("lap_on", actual(), pack_exp(3'd1, 1'b0, 0, 2, 10, 1'b1));
      clk_step(40);
      check("lap_frozen", actual(), pack_exp(3'd1, 1'b0, 0, 2, 10, 1'b1));
      bus.btn_lap = 1'b1;
      clk_step(1);
      check("lap_off", actual(), pack_exp(3'd1, 1'b0, 0, 2, 20, 1'b0));
      bus.btn_lap = 1'b1;
      clk_step(1);
      check("lap_on2", actual(), pack_exp(3'd1, 1'b0, 0, 2, 20, 1'b1));
      bus.btn_start = 1'b1;
      clk_step(1);
      check("lap_pause", actual(), pack_exp(3'd2, 1'b0, 0, 2, 20, 1'b1));
      bus.btn_mode = 1'b1;
      clk_step(1);
      check("lap_idle", actual(), pack_exp(3'd0, 1'b0, 0, 0, 0, 1'b0));
`else
      bus.btn_start = 1'b1;
      clk_step(1);
      clk_step(8);
      bus.btn_lap = 1'b1;
      clk_step(1);
      check("lap_ignored", actual(), pack_exp(3'd1, 1'b0, 0, 0, 2, 1'b0));
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_sequencer.md
Name: stopwatch_sequencer

Overview:
- Control FSM of the stopwatch controller IP. Sequences start, pause and clear, runs the time base, and lets the user set minutes and seconds with the rotary encoder.
- Consumes the encoder's free-running position count plus two pre-debounced single-cycle button pulses.
- Drives the time registers and display values consumed by the 7-segment/AXI readout logic.

Parameters:
- CLK_DIV, 1000000, clk cycles per centisecond tick (sim: 4)
- ENC_W, 8, width of encoder position input
- MAX_MIN, 59, highest minutes value (≤ 63)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- enc_value  in  ENC_W  encoder position count
- btn_start  in  1  start/stop pulse, one cycle
- btn_mode  in  1  mode/clear pulse, one cycle
- btn_lap  in  1  lap pulse (used only with LAP_EN)
- state  out  3  FSM state code
- running  out  1  high in RUN
- overflow  out  1  time saturated at MAX_MIN:59.99
- disp_min  out  6  displayed minutes
- disp_sec  out  6  displayed seconds
- disp_cs  out  7  displayed centiseconds
- lap_active  out  1  display frozen on lap value

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, and the time registers min, sec and cs all =0.
  - prescaler=0, overflow=0, lap_active=0.
  - enc_prev loaded with enc_value.
  - All outputs 0 on the following cycle.
- State codes: IDLE=0, RUN=1, PAUSE=2, SET_MIN=3, SET_SEC=4; codes 5-7 are unreachable and go to IDLE.
- Transitions, evaluated each cycle; btn_start has priority over btn_mode when both are high:
  - IDLE: start→RUN; mode→SET_MIN.
  - RUN: start→PAUSE; mode ignored.
  - PAUSE: start→RUN; mode→IDLE and clears min/sec/cs and overflow.
  - SET_MIN: start→RUN; mode→SET_SEC.
  - SET_SEC: start→RUN; mode→IDLE, keeping the set value.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in RUN.
  - Forced to 0 on every cycle not in RUN, so the first tick comes CLK_DIV cycles after entering RUN.
  - Tick is asserted in the cycle the count equals CLK_DIV-1.
- Time increment on tick:
  - cs 0..99; wraps to 0 and carries into sec.
  - sec 0..59; wraps to 0 and carries into min.
  - At MAX_MIN:59.99 a tick does not wrap: time holds, overflow=1, state→PAUSE in the same cycle.
- Encoder delta:
  - enc_prev registered every cycle; delta = enc_value - enc_prev, modulo 2^ENC_W.
  - delta==1 means +1; delta==all-ones means -1 (covers 0↔max wrap of the encoder count); any other delta is ignored.
  - Delta is applied only in SET_MIN/SET_SEC and discarded in other states.
- Setting fields:
  - SET_MIN: min ±1, wrapping within 0..MAX_MIN.
  - SET_SEC: sec ±1, wrapping within 0..59.
  - cs is cleared on entry to SET_MIN.
- running = (state==RUN), registered with state.
- disp_* = min/sec/cs (live, same cycle as registers) unless lap_active.
- Latency: a button pulse at edge N gives the new state at edge N+1; an encoder step at edge N gives the new field value at edge N+1.
- Reset mid-RUN aborts immediately; no tick is issued in the reset cycle.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- With the macro:
  - btn_lap in RUN toggles lap_active.
  - On 0→1, disp_* load the current min/sec/cs and hold while counting continues.
  - On 1→0, disp_* follow live time again.
  - lap_active clears on leaving RUN to IDLE or SET; it stays frozen in PAUSE.
  - btn_lap in other states is ignored.
- Without the macro: btn_lap is ignored, lap_active is tied 0, and disp_* always show live time.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state codes
  - CS_MAX=99, SEC_MAX=59
  - field widths 6/6/7
- One sub-module: stopwatch_tick_gen (prescaler; inputs clk, rst, en; output tick; parameter CLK_DIV).

Test Plan:
- Reset then CLK_DIV=4; btn_start 1 cycle → state=1 next edge; after 400 cycles disp=00:01.00; btn_start → state=2 and time holds across 50 idle cycles.
- Preload via SET to MAX_MIN=59, 59 s, run to 59:59.99 → the next tick holds at 59:59.99, overflow=1, state=2; btn_mode → 00:00.00, overflow=0, state=0.
- IDLE btn_mode → SET_MIN:
  - enc_value 0→255 (−1) gives min=59.
  - 255→0→1 (+2) gives min=1.
  - btn_mode → SET_SEC; enc 1→0 gives sec=59.
  - btn_mode → IDLE showing 01:59.00.
- btn_start and btn_mode high in the same cycle in IDLE → state=RUN, not SET_MIN; encoder steps in RUN leave time unchanged.
- rst asserted mid-RUN at 00:03.27 → next edge all outputs 0, state=0; no tick during or right after reset.
- (STOPWATCH_LAP_EN) RUN, btn_lap at 00:02.10:
  - disp stays 00:02.10 while internal time advances.
  - A second btn_lap makes disp jump to live time.
  - btn_start then btn_mode leaves lap_active=0.
